// File: rtl/dragon_snoop_bus_arbiter.sv
// Round-robin snooping-bus arbiter for Dragon caches: grant, broadcast, Shared/owner/memory fill, done.
// Optional request statistics counters enabled by defining DRAGON_ARB_STATS_EN.
module dragon_snoop_bus_arbiter #(
  parameter int NUM_CACHES = 2,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CACHES-1:0]            req,
  input  logic [NUM_CACHES-1:0]            req_type,
  input  logic [NUM_CACHES*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CACHES*DATA_WIDTH-1:0] req_data,
  output logic [NUM_CACHES-1:0]            gnt,
  output logic [NUM_CACHES-1:0]            done,
  output logic                             shared_out,
  output logic [DATA_WIDTH-1:0]            resp_data,
  output logic                             bus_valid,
  output logic                             bus_type,
  output logic [ADDR_WIDTH-1:0]            bus_addr,
  output logic [DATA_WIDTH-1:0]            bus_data,
  output logic [$clog2(NUM_CACHES)-1:0]    bus_src,
  input  logic [NUM_CACHES-1:0]            snoop_hit,
  input  logic [NUM_CACHES-1:0]            snoop_dirty,
  input  logic [NUM_CACHES*DATA_WIDTH-1:0] owner_data,
  output logic                             mem_rd_req,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic                             mem_rd_ack,
  input  logic [DATA_WIDTH-1:0]            mem_rd_data
`ifdef DRAGON_ARB_STATS_EN
  ,
  output logic [15:0]                      stat_busrd,
  output logic [15:0]                      stat_busupd,
  output logic [15:0]                      stat_memrd
`endif
);

  localparam int SRC_W = $clog2(NUM_CACHES);

  typedef enum logic [1:0] {IDLE, SNOOP, MEM, DONE} state_t;

  state_t                  state, next_state;
  logic [SRC_W-1:0]        rr_ptr;
  logic                    sel_found;
  logic [SRC_W-1:0]        sel_idx;
  logic [NUM_CACHES-1:0]   others_hit, others_dirty;
  logic                    hit, dirty;
  logic [SRC_W-1:0]        dirty_idx;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_CACHES; i++) begin
      if (!sel_found && req[(int'(rr_ptr) + i) % NUM_CACHES]) begin
        sel_found = 1'b1;
        sel_idx   = SRC_W'((int'(rr_ptr) + i) % NUM_CACHES);
      end
    end
  end

  // The requester's own snoop response never counts toward Shared or ownership.
  always_comb begin
    others_hit   = snoop_hit & ~gnt;
    others_dirty = snoop_dirty & ~gnt;
    hit          = |others_hit;
    dirty        = |others_dirty;
    dirty_idx    = '0;
    for (int i = NUM_CACHES - 1; i >= 0; i--) begin
      if (others_dirty[i]) dirty_idx = SRC_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    bus_valid  = 1'b0;
    done       = '0;
    mem_rd_req = 1'b0;
    mem_addr   = '0;
    case (state)
      IDLE:  if (sel_found) next_state = SNOOP;
      SNOOP: begin
        bus_valid  = 1'b1;
        next_state = (bus_type || dirty) ? DONE : MEM;
      end
      MEM: begin
        mem_rd_req = 1'b1;
        mem_addr   = bus_addr;
        if (mem_rd_ack) next_state = DONE;
      end
      DONE: begin
        done[bus_src] = 1'b1;
        next_state    = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt        <= '0;
      bus_type   <= 1'b0;
      bus_addr   <= '0;
      bus_data   <= '0;
      bus_src    <= '0;
      shared_out <= 1'b0;
      resp_data  <= '0;
      rr_ptr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            gnt      <= NUM_CACHES'(1) << sel_idx;
            bus_type <= req_type[sel_idx];
            bus_addr <= req_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
            bus_data <= req_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
            bus_src  <= sel_idx;
          end
        end
        SNOOP: begin
          shared_out <= hit;
          if (!bus_type && dirty)
            resp_data <= owner_data[dirty_idx*DATA_WIDTH +: DATA_WIDTH];
        end
        MEM: begin
          if (mem_rd_ack) resp_data <= mem_rd_data;
        end
        DONE: begin
          gnt    <= '0;
          rr_ptr <= (bus_src == SRC_W'(NUM_CACHES - 1)) ? '0 : bus_src + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DRAGON_ARB_STATS_EN
  // Saturating counters; memory reads count on entry to MEM, not on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_busrd  <= '0;
      stat_busupd <= '0;
      stat_memrd  <= '0;
    end else begin
      if (state == DONE) begin
        if (bus_type) begin
          if (stat_busupd != 16'hFFFF) stat_busupd <= stat_busupd + 16'd1;
        end else begin
          if (stat_busrd != 16'hFFFF) stat_busrd <= stat_busrd + 16'd1;
        end
      end
      if (state == SNOOP && next_state == MEM && stat_memrd != 16'hFFFF)
        stat_memrd <= stat_memrd + 16'd1;
    end
  end
`endif

endmodule

// File: doc/dragon_snoop_bus_arbiter.md
Name: dragon_snoop_bus_arbiter

Overview:
- Shared snooping-bus stage directly downstream of the per-cache Dragon controllers.
- Takes each cache's bus-transaction request (BusRd or BusUpd) and grants the bus to one requester at a time, round-robin.
- Broadcasts the winning transaction to all other caches, collects their snoop responses into the Shared line, and returns fill data from a dirty owner or from memory.
- Signals completion back to the requester.

Parameters:
- NUM_CACHES, 2, number of cache ports; legal range 2..8.
- ADDR_WIDTH, 15, bus address width.
- DATA_WIDTH, 32, fill/update data width.

Ports:
- clk  in  1  bus clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  NUM_CACHES  per-cache request; held high until that cache's done pulse
- req_type  in  NUM_CACHES  per-cache type; 0=BusRd, 1=BusUpd
- req_addr  in  NUM_CACHES*ADDR_WIDTH  per-cache address, packed with cache 0 in the LSBs
- req_data  in  NUM_CACHES*DATA_WIDTH  per-cache update data, used for BusUpd
- gnt  out  NUM_CACHES  one-hot grant; held for the whole transaction
- done  out  NUM_CACHES  one-cycle completion pulse to the granted cache
- shared_out  out  1  Shared line returned to the requester; valid with done
- resp_data  out  DATA_WIDTH  fill data; valid with done for a BusRd
- bus_valid  out  1  snoop broadcast strobe, high exactly one cycle per transaction
- bus_type  out  1  broadcast transaction type
- bus_addr  out  ADDR_WIDTH  broadcast address
- bus_data  out  DATA_WIDTH  broadcast update data
- bus_src  out  $clog2(NUM_CACHES)  index of the granted cache
- snoop_hit  in  NUM_CACHES  cache holds the line (any state other than NP); sampled while bus_valid is high
- snoop_dirty  in  NUM_CACHES  cache holds the line in M or SM and will supply it; sampled while bus_valid is high
- owner_data  in  NUM_CACHES*DATA_WIDTH  line data from each cache
- mem_rd_req  out  1  memory read request; level signal, held until ack
- mem_addr  out  ADDR_WIDTH  memory read address
- mem_rd_ack  in  1  memory read data valid
- mem_rd_data  in  DATA_WIDTH  memory read data

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, FSM to IDLE, round-robin pointer to 0. Applies mid-transaction: any in-flight transaction is dropped with no done.
- FSM states: IDLE, SNOOP, MEM, DONE.
- IDLE:
  - If any req bit is set, select the first set bit at or after the pointer, wrapping around.
  - Register gnt, bus_type, bus_addr, bus_data and bus_src from that cache's req_type, req_addr and req_data.
  - Next state: SNOOP.
- SNOOP:
  - bus_valid=1 for exactly this one cycle.
  - Mask out the requester's own bit, then compute hit = OR(snoop_hit & ~gnt) and dirty = OR(snoop_dirty & ~gnt).
  - Latch shared_out = hit.
  - BusUpd: next state DONE.
  - BusRd with dirty: latch resp_data from the lowest-index dirty non-requester's owner_data; next state DONE.
  - BusRd without dirty: next state MEM.
- MEM:
  - mem_rd_req=1 and mem_addr=bus_addr, held until mem_rd_ack.
  - On the cycle mem_rd_ack is high: latch resp_data from mem_rd_data, drop mem_rd_req from the next cycle, next state DONE.
  - No limit on how long memory may take.
- DONE:
  - done[bus_src]=1 for one cycle.
  - The pointer moves to bus_src+1, wrapping modulo NUM_CACHES.
  - gnt clears on the next cycle; next state IDLE.
- Latency: BusUpd or dirty BusRd completes 3 cycles after grant (done in the third cycle). A memory BusRd takes 3 + memory wait cycles.
- A requester must drop req in the cycle after done. If req is still high in IDLE, it is arbitrated again as a new transaction.
- Requests that arrive while the bus is busy are ignored until IDLE; a req change mid-transaction has no effect on the granted transaction.
- At most one transaction is in flight; back-to-back transactions are separated by exactly one IDLE cycle.
- resp_data and shared_out hold their values until the next SNOOP.

Optional Feature:
- Macro DRAGON_ARB_STATS_EN.
- Defined:
  - Adds three 16-bit outputs: stat_busrd, stat_busupd and stat_memrd.
  - Each counter increments on the relevant done, or on entry to MEM for stat_memrd.
  - Counters saturate at 16'hFFFF and are cleared by rst_n.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cache 0 BusRd to addr 0x0040, no snoop_hit, memory acks 2 cycles after mem_rd_req -> mem_rd_req held 2 cycles, done[0] pulses, shared_out=0, resp_data=mem_rd_data.
- Cache 1 BusRd, snoop_dirty[0]=1, owner_data[0]=0xAAAAAAAA -> mem_rd_req never asserted, done[1] in the third cycle after grant, shared_out=1, resp_data=0xAAAAAAAA.
- Cache 0 BusUpd with req_data=0x12345678, snoop_hit[1]=1 -> bus_valid one cycle with bus_type=1 and bus_data=0x12345678, shared_out=1, done[0].
- Requester's own snoop_hit/snoop_dirty asserted, no other cache hits -> shared_out=0, memory fill used.
- req=2'b11 held continuously -> grants alternate 0,1,0,1, one IDLE cycle between transactions.
- rst_n low during MEM with mem_rd_req=1 -> all outputs 0 immediately, no done; after release, the next grant goes to cache 0.
